// File: rtl/port_fifo_device_pkg.sv
// Shared constants for the port-bus FIFO responder: register offsets,
// STATUS bit positions and the STATUS packing helper.
package port_fifo_device_pkg;

  localparam int WORD_SIZE_DEF = 16;

  localparam logic [1:0] PORT_OFF_DATA    = 2'd0;
  localparam logic [1:0] PORT_OFF_STATUS  = 2'd1;
  localparam logic [1:0] PORT_OFF_TXCOUNT = 2'd2;
  localparam logic [1:0] PORT_OFF_RXCOUNT = 2'd3;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_FULL      = 2;
  localparam int ST_RX_EMPTY     = 3;
  localparam int ST_TX_OVERFLOW  = 4;
  localparam int ST_RX_UNDERFLOW = 5;

  function automatic logic [5:0] pack_status(
    input logic tx_full, input logic tx_empty,
    input logic rx_full, input logic rx_empty,
    input logic tx_ovf,  input logic rx_unf
  );
    logic [5:0] s;
    s                  = '0;
    s[ST_TX_FULL]      = tx_full;
    s[ST_TX_EMPTY]     = tx_empty;
    s[ST_RX_FULL]      = rx_full;
    s[ST_RX_EMPTY]     = rx_empty;
    s[ST_TX_OVERFLOW]  = tx_ovf;
    s[ST_RX_UNDERFLOW] = rx_unf;
    return s;
  endfunction

endpackage

// File: rtl/port_fifo_device_if.sv
// CPU port bus plus the TX/RX valid/ready streams of the FIFO responder.
interface port_fifo_device_if
  import port_fifo_device_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF
);
  logic [WORD_SIZE-1:0] portaddr;
  logic [WORD_SIZE-1:0] portval;
  logic                 portget;
  logic                 portset;
  logic [WORD_SIZE-1:0] portout;
  logic [WORD_SIZE-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [WORD_SIZE-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output portaddr, portval, portget, portset, tx_ready, rx_data, rx_valid,
    input  portout, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  portaddr, portval, portget, portset, tx_ready, rx_data, rx_valid,
    output portout, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/port_fifo_device_sync_fifo.sv
// Synchronous FIFO: pushes on full and pops on empty are dropped, and the
// head word is presented combinationally (zero while empty).
module port_fifo_device_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/port_fifo_device.sv
// Port-bus responder: decodes a 4-word window, buffers CPU writes in a TX
// FIFO, serves CPU reads from an RX FIFO, and exposes status and counts.
module port_fifo_device
  import port_fifo_device_pkg::*;
#(
  parameter int                   WORD_SIZE = WORD_SIZE_DEF,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR = WORD_SIZE'(16'h0010),
  parameter int                   DEPTH     = 4
) (
  input logic               clk,
  input logic               do_reset_n,
  port_fifo_device_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 w_hit;
  logic [1:0]           w_off;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_tx_push;
  logic                 w_tx_pop;
  logic                 w_rx_push;
  logic                 w_rx_pop;
  logic                 w_tx_full;
  logic                 w_tx_empty;
  logic                 w_rx_full;
  logic                 w_rx_empty;
  logic [CW-1:0]        w_tx_count;
  logic [CW-1:0]        w_rx_count;
  logic [WORD_SIZE-1:0] w_rx_dout;
  logic [WORD_SIZE-1:0] w_status;
  logic                 r_tx_ovf;
  logic                 r_rx_unf;
  logic [WORD_SIZE-1:0] r_portout;

  assign w_hit = (bus.portaddr[WORD_SIZE-1:2] == BASE_ADDR[WORD_SIZE-1:2]);
  assign w_off = bus.portaddr[1:0];
  assign w_rd  = bus.portget & w_hit;
  assign w_wr  = bus.portset & w_hit;

  assign w_tx_push = w_wr & (w_off == PORT_OFF_DATA);
  assign w_tx_pop  = bus.tx_valid & bus.tx_ready;
  assign w_rx_push = bus.rx_valid & bus.rx_ready;
  assign w_rx_pop  = w_rd & (w_off == PORT_OFF_DATA);

  assign bus.tx_valid = ~w_tx_empty;
  assign bus.rx_ready = ~w_rx_full;
  assign bus.portout  = r_portout;

  assign w_status = WORD_SIZE'(pack_status(w_tx_full, w_tx_empty, w_rx_full,
                                           w_rx_empty, r_tx_ovf, r_rx_unf));

  port_fifo_device_sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (do_reset_n),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_din   (bus.portval),
    .o_dout  (bus.tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  port_fifo_device_sync_fifo #(.WIDTH(WORD_SIZE), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (do_reset_n),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_din   (bus.rx_data),
    .o_dout  (w_rx_dout),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  // All read sources are pre-edge values; an empty RX head reads as zero.
  always_ff @(posedge clk or negedge do_reset_n) begin
    if (!do_reset_n) begin
      r_portout <= '0;
      r_tx_ovf  <= 1'b0;
      r_rx_unf  <= 1'b0;
    end else begin
      if (w_rd) begin
        case (w_off)
          PORT_OFF_DATA:    r_portout <= w_rx_dout;
          PORT_OFF_STATUS:  r_portout <= w_status;
          PORT_OFF_TXCOUNT: r_portout <= WORD_SIZE'(w_tx_count);
          PORT_OFF_RXCOUNT: r_portout <= WORD_SIZE'(w_rx_count);
        endcase
      end
      if (w_wr && (w_off == PORT_OFF_STATUS)) begin
        r_tx_ovf <= 1'b0;
        r_rx_unf <= 1'b0;
      end else begin
        if (w_tx_push && w_tx_full)  r_tx_ovf <= 1'b1;
        if (w_rx_pop  && w_rx_empty) r_rx_unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_port_fifo_device.sv
// Randomized scoreboard bench for port_fifo_device against a queue-based
// model of the register map and the two FIFOs.
module tb_port_fifo_device;
  import port_fifo_device_pkg::*;

  localparam int          W     = 16;
  localparam logic [15:0] BASE  = 16'h0010;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic do_reset_n = 1'b0;
  always #5 clk = ~clk;

  port_fifo_device_if #(.WORD_SIZE(W)) bus ();

  port_fifo_device #(.WORD_SIZE(W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .do_reset_n (do_reset_n),
    .bus        (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] m_tx  [$];
  logic [15:0] m_rx  [$];
  logic [15:0] m_exp [$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;
  bit          m_rd_pending = 1'b0;
  logic [15:0] m_portout = 16'h0000;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_exp.delete();
    m_ovf        = 1'b0;
    m_unf        = 1'b0;
    m_rd_pending = 1'b0;
    m_portout    = 16'h0000;
  endtask

  // Reference model: at each falling edge, look at the inputs that the next
  // rising edge will act on, predict the read result and apply the effects.
  always @(negedge clk) begin
    int          txn;
    int          rxn;
    bit          hit;
    logic [1:0]  off;
    bit          tx_pop;
    logic [15:0] e;
    if (do_reset_n) begin
      txn = m_tx.size();
      rxn = m_rx.size();
      hit = (bus.portaddr[15:2] == BASE[15:2]);
      off = bus.portaddr[1:0];
      check("tx_valid", bus.tx_valid, txn != 0);
      if (txn != 0) check("tx_data", bus.tx_data, m_tx[0]);
      check("rx_ready", bus.rx_ready, rxn < DEPTH);
      tx_pop = (txn != 0) && bus.tx_ready;
      m_rd_pending = 1'b0;
      if (bus.portget && hit) begin
        case (off)
          2'd0:    e = (rxn != 0) ? m_rx[0] : 16'h0000;
          2'd1:    e = {10'b0, m_unf, m_ovf, rxn == 0, rxn == DEPTH, txn == 0, txn == DEPTH};
          2'd2:    e = 16'(txn);
          default: e = 16'(rxn);
        endcase
        m_exp.push_back(e);
        m_rd_pending = 1'b1;
        if (off == 2'd0) begin
          if (rxn != 0) void'(m_rx.pop_front());
          else          m_unf = 1'b1;
        end
      end
      if (tx_pop) void'(m_tx.pop_front());
      if (bus.portset && hit && off == 2'd0) begin
        if (txn == DEPTH) m_ovf = 1'b1;
        else              m_tx.push_back(bus.portval);
      end
      if (bus.portset && hit && off == 2'd1) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (bus.rx_valid && rxn < DEPTH) m_rx.push_back(bus.rx_data);
    end
  end

  // Monitor: after every edge, pop the predicted read (if one was issued)
  // and compare portout, which must otherwise hold its previous value.
  always @(posedge clk) begin
    #1;
    if (do_reset_n) begin
      if (m_rd_pending) m_portout = m_exp.pop_front();
      check("portout", bus.portout, m_portout);
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] v, input bit g, input bit s);
    @(posedge clk);
    #1;
    bus.portaddr = a;
    bus.portval  = v;
    bus.portget  = g;
    bus.portset  = s;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    drive(a, v, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [15:0] a);
    drive(a, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic idle();
    drive(BASE, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    do_reset_n = 1'b0;
    #1;
    check("rst_rx_ready", bus.rx_ready, 16'h0001);
    check("rst_tx_valid", bus.tx_valid, 16'h0000);
    check("rst_portout", bus.portout, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    do_reset_n = 1'b1;
  endtask

  initial begin
    bus.portaddr = '0;
    bus.portval  = '0;
    bus.portget  = 1'b0;
    bus.portset  = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_portout", bus.portout, 16'h0000);
    check("reset_tx_valid", bus.tx_valid, 16'h0000);
    check("reset_tx_data", bus.tx_data, 16'h0000);
    check("reset_rx_ready", bus.rx_ready, 16'h0001);
    do_reset_n = 1'b1;

    rd(BASE + 16'd1); idle();
    check("status_after_reset", bus.portout, 16'h000A);

    wr(BASE, 16'h1234); wr(BASE, 16'hABCD); idle();
    check("tx_head", bus.tx_data, 16'h1234);
    rd(BASE + 16'd2); idle();
    check("txcount_2", bus.portout, 16'h0002);
    bus.tx_ready = 1'b1;
    idle(); idle();
    bus.tx_ready = 1'b0;
    check("tx_drained", bus.tx_valid, 16'h0000);

    for (int i = 0; i < 5; i++) wr(BASE, 16'h5000 + 16'(i));
    rd(BASE + 16'd2); idle();
    check("txcount_full", bus.portout, 16'h0004);
    rd(BASE + 16'd1); idle();
    check("status_overflow", bus.portout, 16'h0019);
    wr(BASE + 16'd1, 16'h0000);
    rd(BASE + 16'd1); idle();
    check("status_cleared", bus.portout, 16'h0009);
    bus.tx_ready = 1'b1;
    repeat (5) idle();
    bus.tx_ready = 1'b0;

    bus.rx_valid = 1'b1; bus.rx_data = 16'h0042; idle();
    bus.rx_data = 16'h0043; idle();
    bus.rx_valid = 1'b0;
    rd(BASE + 16'd3); idle();
    check("rxcount_2", bus.portout, 16'h0002);
    rd(BASE); idle();
    check("rx_pop_0042", bus.portout, 16'h0042);
    rd(BASE); idle();
    check("rx_pop_0043", bus.portout, 16'h0043);
    rd(BASE); idle();
    check("rx_underflow_data", bus.portout, 16'h0000);
    rd(BASE + 16'd1); idle();
    check("status_underflow", bus.portout, 16'h002A);
    wr(BASE + 16'd1, 16'h0000);

    rd(BASE + 16'd1); idle();
    wr(BASE + 16'd4, 16'hFFFF);
    rd(BASE - 16'd1); idle();
    check("outside_read_holds", bus.portout, 16'h000A);
    rd(BASE + 16'd2); idle();
    check("outside_write_ignored", bus.portout, 16'h0000);

    bus.rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.rx_data = 16'h0070 + 16'(i);
      idle();
    end
    bus.rx_valid = 1'b0;
    rd(BASE + 16'd3); idle();
    check("rxcount_3", bus.portout, 16'h0003);
    async_reset();
    rd(BASE + 16'd3); idle();
    check("rxcount_after_reset", bus.portout, 16'h0000);

    for (int i = 0; i < 1500; i++) begin
      int          r;
      logic [15:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 8)       a = BASE + 16'(r % 4);
      else if (r == 8) a = BASE + 16'd4 + 16'($urandom_range(0, 3));
      else             a = 16'($urandom);
      drive(a, 16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      bus.tx_ready = 1'($urandom_range(0, 1));
      bus.rx_valid = 1'($urandom_range(0, 1));
      bus.rx_data  = 16'($urandom);
      if (i % 400 == 399) async_reset();
    end
    bus.rx_valid = 1'b0;
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/port_fifo_device.md
Name: port_fifo_device

Overview:
- Port-bus responder: the peripheral end of the CPU's port I/O interface (portaddr/portval/portget/portset/portout).
- Decodes a 4-word address window. CPU writes are buffered in a TX FIFO drained by an external valid/ready consumer.
- An external valid/ready producer fills an RX FIFO that the CPU reads back. Status and occupancy are port-readable.

Parameters:
WORD_SIZE, 16, port address/data width (from parameters.v)
BASE_ADDR, 16'h0010, first address of window; must be 4-aligned
DEPTH, 4, entries per FIFO; power of 2, >= 2

Ports:
clk  input  1  system clock, all state on rising edge
do_reset_n  input  1  asynchronous, active-low reset
portaddr  input  WORD_SIZE  port address from CPU
portval  input  WORD_SIZE  write data from CPU
portget  input  1  one-cycle read strobe
portset  input  1  one-cycle write strobe
portout  output  WORD_SIZE  registered read data to CPU
tx_data  output  WORD_SIZE  head of TX FIFO
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  consumer accepts tx_data when tx_valid & tx_ready
rx_data  input  WORD_SIZE  producer data
rx_valid  input  1  producer offers rx_data
rx_ready  output  1  RX FIFO not full

Behaviour:
- Reset (do_reset_n low, async): both FIFOs empty, pointers 0, sticky flags 0, portout=0, tx_valid=0, tx_data=0, rx_ready=1.
- Decode: hit when portaddr[WORD_SIZE-1:2] == BASE_ADDR[WORD_SIZE-1:2]. Offset = portaddr[1:0]. Strobes outside the window are ignored (no state change; portout holds).
- Register map:
  - Offset 0 DATA. Write pushes portval into TX. Read pops RX head into portout.
  - Offset 1 STATUS. Read returns bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_overflow, bit5 rx_underflow; other bits 0. Any write clears bits 4-5.
  - Offset 2 TXCOUNT. Read only; writes ignored.
  - Offset 3 RXCOUNT. Read only; writes ignored.
- Read latency:
  - portout loads on the rising edge where portget is high and the address hits. It holds until the next decoded read.
  - STATUS/COUNT values are those before any same-edge FIFO update.
- Write: takes effect on the rising edge where portset is high.
- TX push when full: word dropped, tx_overflow set. A same-cycle tx pop does NOT rescue it; full is evaluated pre-edge.
- RX read when empty: portout=0, rx_underflow set, pointers unchanged.
- External handshakes:
  - TX pop on tx_valid & tx_ready.
  - RX push on rx_valid & rx_ready.
  - rx_ready and tx_valid are derived combinationally from registered counts.
- Simultaneous events:
  - Push and pop of the same FIFO in one edge (non-full, non-empty): both occur, count unchanged.
  - On an empty FIFO, push and pop in the same edge is impossible by construction, since valid is 0.
  - portget and portset both high: each handled per its own decode. A read of STATUS plus a write to STATUS returns pre-clear flags.
- Counts: width clog2(DEPTH)+1, range 0..DEPTH. Pointers wrap modulo DEPTH.
- Reset mid-transfer: all in-flight data discarded. No handshake completes on the reset edge.

Decomposition:
- parameters.v gains:
  - PORT_OFF_DATA=0, PORT_OFF_STATUS=1, PORT_OFF_TXCOUNT=2, PORT_OFF_RXCOUNT=3
  - ST_TX_FULL..ST_RX_UNDERFLOW bit indices (0..5)
- Sub-module sync_fifo is instantiated twice (TX, RX). Its interface:
  - push/pop/din/dout/full/empty/count
  - async active-low reset, drop-on-full, dout = head word combinationally
- port_fifo_device holds only decode, status/sticky logic and the portout register.

Test Plan:
- Reset, then read STATUS at BASE+1 -> portout=16'h000A (tx_empty, rx_empty); rx_ready=1, tx_valid=0.
- portset BASE+0 with 16'h1234 then 16'hABCD, tx_ready=0 -> tx_valid=1, tx_data=16'h1234, TXCOUNT read=2. Raise tx_ready 2 cycles -> 1234 then ABCD consumed, tx_valid=0.
- Write 5 words to DATA with DEPTH=4, tx_ready=0 -> TXCOUNT=4, STATUS bit0=1, bit4=1. Write STATUS -> bit4 cleared, FIFO contents unchanged.
- Producer drives 16'h0042, 16'h0043 -> RXCOUNT=2. Two DATA reads -> portout 0042 then 0043. Third read -> portout=0, STATUS bit5=1.
- portset to BASE+4 (outside window) with 16'hFFFF -> TXCOUNT unchanged. portget to BASE-1 -> portout unchanged.
- Fill RX to 3/4, assert do_reset_n=0 asynchronously mid-cycle -> rx_ready=1, RXCOUNT=0, portout=0 immediately, without waiting for clk.
